// File: rtl/lsu_axi_master.sv
// rtl/lsu_axi_master.sv - single-outstanding AXI-lite master for core load/store requests
// Optional LSU_AXI_ALIGN_CHECK_EN: misaligned requests are answered locally with rsp_err=1.
module lsu_axi_master (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, RSP} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_done;
  logic        w_done;

`ifdef LSU_AXI_ALIGN_CHECK_EN
  logic misaligned;
  always_comb begin
    misaligned = 1'b0;
    if (!req_we) begin
      misaligned = (req_addr[1:0] != 2'b00);
    end else begin
      misaligned = !((req_wstrb == (4'b0001 << req_addr[1:0])) ||
                     (req_addr[1:0] == 2'd0 && req_wstrb == 4'b0011) ||
                     (req_addr[1:0] == 2'd2 && req_wstrb == 4'b1100) ||
                     (req_addr[1:0] == 2'd0 && req_wstrb == 4'b1111));
    end
  end
`endif

  // Every handshake output is a pure decode of registered state, so no input reaches an output.
  assign req_ready = (state == IDLE);
  assign arvalid   = (state == RADDR);
  assign rready    = (state == RDATA);
  assign awvalid   = (state == WREQ) && !aw_done;
  assign wvalid    = (state == WREQ) && !w_done;
  assign bready    = (state == WRESP);
  assign rsp_valid = (state == RSP);
  assign araddr    = arvalid ? addr_q  : 32'd0;
  assign awaddr    = awvalid ? addr_q  : 32'd0;
  assign wdata     = wvalid  ? wdata_q : 32'd0;
  assign wstrb     = wvalid  ? wstrb_q : 4'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
`ifdef LSU_AXI_ALIGN_CHECK_EN
            if (misaligned) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'd0;
              state     <= RSP;
            end else
`endif
            begin
              if (req_we) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                state   <= WREQ;
              end else begin
                state <= RADDR;
              end
            end
          end
        end
        RADDR: if (arready) state <= RDATA;
        RDATA: begin
          if (rvalid) begin
            rsp_rdata <= rdata;
            rsp_err   <= (rresp != 2'b00);
            state     <= RSP;
          end
        end
        WREQ: begin
          if (awready && !aw_done) aw_done <= 1'b1;
          if (wready && !w_done) w_done <= 1'b1;
          // Either channel may finish first, or both in the same cycle.
          if ((aw_done || awready) && (w_done || wready)) state <= WRESP;
        end
        WRESP: begin
          if (bvalid) begin
            rsp_err   <= (bresp != 2'b00);
            rsp_rdata <= 32'd0;
            state     <= RSP;
          end
        end
        RSP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axi_master.sv
// tb/tb_lsu_axi_master.sv - directed self-checking bench for lsu_axi_master
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_axi_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one cycle; sampling happens on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    rsp_ready = 1; arready = 0; rdata = 0; rresp = 0; rvalid = 0;
    awready = 0; wready = 0; bresp = 0; bvalid = 0;
    #2;
    check("rst_req_ready", req_ready, 1);
    check("rst_axi_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
    check("rst_rsp", {rsp_valid, rsp_err}, 0);
    check("rst_rdata", rsp_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Load, zero-wait slave
    req_valid = 1; req_we = 0; req_addr = 32'h8000_0004;
    arready = 1; rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 0;
    tick();
    req_valid = 0;
    check("ld_c1_arvalid", arvalid, 1);
    check("ld_c1_araddr", araddr, 32'h8000_0004);
    check("ld_c1_req_ready", req_ready, 0);
    tick();
    check("ld_c2_rready", {arvalid, rready}, 2'b01);
    tick();
    check("ld_c3_rsp_valid", rsp_valid, 1);
    check("ld_c3_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("ld_c3_err", rsp_err, 0);
    arready = 0; rvalid = 0;
    tick();
    check("ld_back_idle", {req_ready, rsp_valid}, 2'b10);

    // Store: awready at cycle 1, wready at cycle 3
    req_valid = 1; req_we = 1; req_addr = 32'h8000_0010; req_wdata = 32'h1234_5678; req_wstrb = 4'b1111;
    awready = 1; wready = 0;
    tick();
    req_valid = 0;
    check("st_c1_valids", {awvalid, wvalid}, 2'b11);
    check("st_c1_awaddr", awaddr, 32'h8000_0010);
    check("st_c1_wdata", wdata, 32'h1234_5678);
    check("st_c1_wstrb", wstrb, 4'b1111);
    tick();
    check("st_c2_valids", {awvalid, wvalid}, 2'b01);
    check("st_c2_wdata", wdata, 32'h1234_5678);
    tick();
    check("st_c3_wvalid", wvalid, 1);
    check("st_c3_wdata", wdata, 32'h1234_5678);
    wready = 1;
    tick();
    check("st_c4_bready", {wvalid, bready}, 2'b01);
    check("st_c4_no_rsp", rsp_valid, 0);
    bvalid = 1; bresp = 0;
    tick();
    check("st_c5_rsp", {rsp_valid, rsp_err}, 2'b10);
    check("st_c5_rdata", rsp_rdata, 0);
    bvalid = 0; wready = 0; awready = 0;
    tick();

    // Load with AR stall then R stall and SLVERR, followed by core stall in RSP
    req_valid = 1; req_we = 0; req_addr = 32'h8000_0020;
    arready = 0; rvalid = 0; rdata = 32'hCAFE_F00D; rresp = 2'b10;
    tick();
    req_valid = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) arready = 1;
      check($sformatf("ar_stall_%0d", i), {arvalid, araddr}, {1'b1, 32'h8000_0020});
      tick();
    end
    arready = 0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("r_stall_%0d", i), {rready, rsp_valid}, 2'b10);
      tick();
    end
    rvalid = 1; rsp_ready = 0;
    tick();
    rvalid = 0;
    req_valid = 1; req_we = 1; req_addr = 32'h8000_0030; req_wdata = 32'hA5A5_5A5A; req_wstrb = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rsp_hold_%0d", i), {rsp_valid, req_ready, rsp_err, awvalid}, 4'b1010);
      check($sformatf("rsp_hold_rdata_%0d", i), rsp_rdata, 32'hCAFE_F00D);
      tick();
    end
    rsp_ready = 1;
    tick();
    check("post_rsp_idle", {req_ready, awvalid, rsp_valid}, 3'b100);
    tick();
    req_valid = 0;
    check("pend_store_wreq", {awvalid, wvalid, req_ready}, 3'b110);

    // Asynchronous reset while in WREQ
    #2;
    rst_n = 0;
    #1;
    check("arst_valids", {awvalid, wvalid}, 2'b00);
    check("arst_req_ready", req_ready, 1);
    check("arst_no_rsp", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    tick();
    check("arst_stays_idle", {req_ready, rsp_valid, awvalid, wvalid}, 4'b1000);

    // Misaligned load
    req_valid = 1; req_we = 0; req_addr = 32'h8000_0002;
    arready = 0; rvalid = 0; rdata = 32'h0BAD_0BAD; rresp = 0;
    tick();
    req_valid = 0;
`ifdef LSU_AXI_ALIGN_CHECK_EN
    check("mis_c1_no_ar", arvalid, 0);
    check("mis_c1_rsp", {rsp_valid, rsp_err}, 2'b11);
    check("mis_c1_rdata", rsp_rdata, 0);
    tick();
`else
    check("mis_c1_ar", {arvalid, araddr}, {1'b1, 32'h8000_0002});
    arready = 1; rvalid = 1;
    tick();
    tick();
    arready = 0; rvalid = 0;
    check("mis_rsp", {rsp_valid, rsp_err}, 2'b10);
    check("mis_rdata", rsp_rdata, 32'h0BAD_0BAD);
    tick();
`endif
    check("end_idle", req_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_axi_master.md
# lsu_axi_master

AXI-lite master that turns single load/store requests from the core's memory stage into AXI-lite transactions toward `isram`-style slaves (data SRAM, future UART/CLINT). One transaction is outstanding at a time. Read data or write completion returns on a valid/ready response port. This block is the initiator side of the same AXI-lite channel set that the memory slaves respond to.

## Interface
Parameters: none. Widths come from `defines.svh`: `AXI_ADDR_BUS` 32, `AXI_DATA_BUS` 32, `AXI_RESP_BUS` 2, `AXI_WSTRB_BUS` 4.
- clk  in  1  clock; single clock domain, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  core request valid
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, lane-aligned
- req_wstrb  in  4  store byte strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  32  load data; 0 for stores
- rsp_err  out  1  slave returned non-OKAY, or local alignment fault
- araddr/arvalid/arready, rdata/rresp/rvalid/rready, awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready  AXI-lite master side; directions are the mirror of the slave and widths follow the bus macros.

## Operation
- States: IDLE, RADDR, RDATA, WREQ, WRESP, RSP.
- IDLE: req_ready=1. On req_valid, latch addr, wdata, wstrb, and we into registers. A load goes to RADDR. A store goes to WREQ, and aw_done and w_done are cleared.
- RADDR: arvalid=1, araddr=latched addr. On arready, go to RDATA.
- RDATA: rready=1. On rvalid, capture rdata into rsp_rdata, set rsp_err=(rresp!=2'b00), and go to RSP.
- WREQ: awvalid=!aw_done and wvalid=!w_done, both asserted in the same first cycle. Each channel's done flag sets on its own handshake. Go to WRESP once both are done, including when both complete in the same cycle.
- WRESP: bready=1. On bvalid, set rsp_err=(bresp!=2'b00), set rsp_rdata=0, and go to RSP.
- RSP: rsp_valid=1. On rsp_ready, go to IDLE.
- araddr/awaddr/wdata/wstrb are driven from latched registers. They stay stable while their valid is high, per AXI. A valid never drops before its handshake.
- Unused AXI outputs are 0 when not in their state.

## Timing
- Reset (async, rst_n=0): state=IDLE immediately.
  - Outputs take their values without waiting for a clock edge: arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err = 0; rsp_rdata = 0; req_ready = 1.
  - A mid-transaction reset discards the pending transaction. No response is produced.
- req_ready, all AXI valid/ready outputs, and rsp_valid are decoded from registered state and flags only. There is no combinational path from any input to any output.
- Minimum load latency with zero-wait slave: accept at cycle 0, arvalid at cycle 1, rready at cycle 2, rsp_valid at cycle 3.
- Minimum store latency: accept at 0, AW+W at 1, bready at 2, rsp_valid at 3.
- Slave stalls (arready/wready/awready/rvalid/bvalid low) hold the current state indefinitely. No timeout.
- Core stall (rsp_ready low) holds RSP. rsp_rdata and rsp_err stay stable.
- Throughput: at most one transaction per 4 cycles. A new request is accepted only in IDLE.

## Configuration
- `LSU_AXI_ALIGN_CHECK_EN` defined:
  - In IDLE, a request faults if it is a load with req_addr[1:0]!=0, or a store whose wstrb pattern is not one of 0001<<k, 0011/1100, or 1111 matching addr[1:0].
  - A faulting request goes directly to RSP with rsp_err=1 and rsp_rdata=0. No AXI channel is asserted.
- Undefined: no check. Every request is issued on AXI as given.

## Test plan
- Load, zero-wait slave returning rdata=0xDEADBEEF, rresp=0 at addr 0x8000_0004 -> araddr=0x8000_0004 at cycle 1; rsp_valid at cycle 3 with rsp_rdata=0xDEADBEEF and rsp_err=0.
- Store, addr 0x8000_0010, wdata=0x12345678, wstrb=1111; awready at cycle 1, wready at cycle 3 -> awvalid drops after cycle 1; wvalid holds to cycle 3 with wdata stable; bready from cycle 4; rsp_valid after bvalid.
- Load with arready held low 5 cycles, then rvalid delayed 3 cycles with rresp=2'b10 -> araddr stable for all 6 cycles; rsp_err=1.
- rsp_ready low 4 cycles in RSP -> rsp_valid, rsp_rdata, and req_ready=0 are held; the next req_valid is ignored until the cycle after the response handshake.
- rst_n pulsed low while in WREQ -> awvalid/wvalid drop to 0 without a clock edge; req_ready=1; no rsp_valid.
- With `LSU_AXI_ALIGN_CHECK_EN`, load at 0x8000_0002 -> no arvalid; rsp_valid at cycle 1 with rsp_err=1. Without the macro, arvalid is asserted with araddr=0x8000_0002.
